// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, constants and width helper for the fetch stage
package fetch_pkg;

  localparam int FETCH_DATA_WIDTH = 32;
  localparam int FETCH_ADDR_WIDTH = 32;
  localparam int INST_BYTES       = FETCH_DATA_WIDTH / 8;

  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0] pc;
    logic [FETCH_DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Smallest r with 2**r >= value; used to size counters and pointers.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with push, pop, priority flush and occupancy count
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type T     = fetch_entry_t,
  parameter int  DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        push,
  input  T                            push_data,
  input  logic                        pop,
  output T                            head,
  output logic [clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy update; flush empties the queue and wins over push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write; slots are only read once occupied, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC generator, memory request/response port and instruction queue toward decode
// Optional feature macro: FETCH_STAGE_PERF_EN adds perf_fetched and perf_stall counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0,
  parameter int                    FIFO_DEPTH      = 4,
  parameter int                    MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc
`ifdef FETCH_STAGE_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stall
`endif
);

  localparam int                    IW   = clog2(MAX_OUTSTANDING + 1);
  localparam int                    QW   = clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [IW-1:0]         inflight;
  logic [IW-1:0]         inflight_next;
  logic [IW-1:0]         drop_cnt;
  logic [IW-1:0]         drop_next;
  logic [IW-1:0]         live;
  logic [IW-1:0]         pc_q_count;
  logic [QW-1:0]         q_count;
  logic                  fire;
  logic                  rsp_ok;
  logic                  drop_hit;
  logic                  push;
  logic                  pop;
  entry_t                push_entry;
  entry_t                q_head;
  addr_t                 rsp_pc;

  assign req_addr   = pc;
  assign inst_valid = (q_count != '0);
  assign inst_data  = inst_valid ? q_head.instr : '0;
  assign inst_pc    = inst_valid ? q_head.pc : '0;
  assign push_entry = '{pc: rsp_pc, instr: rsp_data};

  // Credit check, handshakes and next values for the PC and request counters.
  always_comb begin
    live          = inflight - drop_cnt;
    req_valid     = (32'(inflight) < MAX_OUTSTANDING) &&
                    ((32'(q_count) + 32'(live)) < FIFO_DEPTH);
    fire          = req_valid && req_ready;
    rsp_ok        = rsp_valid && (inflight != '0);
    drop_hit      = rsp_ok && (drop_cnt != '0);
    push          = rsp_ok && !drop_hit && !redirect_valid;
    pop           = inst_valid && inst_ready && !redirect_valid;
    inflight_next = inflight + IW'(fire) - IW'(rsp_ok);
    drop_next     = drop_cnt - IW'(drop_hit);
    pc_next       = fire ? pc + STEP : pc;
    if (redirect_valid) begin
      // Everything still in flight after this edge, including a request
      // firing now, belongs to the old path.
      drop_next = inflight_next;
      pc_next   = redirect_pc;
    end
  end

  // Fetch state: PC, requests in flight and stale responses still to discard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      pc       <= pc_next;
      inflight <= inflight_next;
      drop_cnt <= drop_next;
    end
  end

  fetch_fifo #(
    .T     (entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (q_head),
    .count     (q_count)
  );

  // Request addresses are never flushed: stale responses still consume their entry.
  fetch_fifo #(
    .T     (addr_t),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (fire),
    .push_data (pc),
    .pop       (rsp_ok),
    .head      (rsp_pc),
    .count     (pc_q_count)
  );

`ifdef FETCH_STAGE_PERF_EN
  // Decode-side counters: delivered instructions and cycles decode waited on an empty queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop)                      perf_fetched <= perf_fetched + 32'd1;
      if (inst_ready && !inst_valid) perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_rsp_without_req: assert property (@(posedge clk) disable iff (!rst)
    !(rsp_valid && (inflight == '0)))
    else $error("fetch_stage: response with no request in flight");

  a_pc_q_tracks_inflight: assert property (@(posedge clk) disable iff (!rst)
    pc_q_count == inflight)
    else $error("fetch_stage: request address queue out of step with inflight count");
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage with a fixed-latency memory model
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_STAGE_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int          n_checks;
  int          n_errors;
  int          edge_no;
  int          lat;
  int          n_fire;
  int          waited;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];

  fetch_stage #(
    .DATA_WIDTH      (32),
    .ADDR_WIDTH      (32),
    .RESET_PC        (32'h0),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
`ifdef FETCH_STAGE_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // One clock: memory drives a due response, fires are recorded, then wait to the next negedge.
  task automatic tick();
    if (rst && pend_due.size() > 0 && pend_due[0] <= edge_no + 1) begin
      rsp_valid = 1'b1;
      rsp_data  = ~pend_addr[0];
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
    end
    #1;
    if (rst) begin
      if (rsp_valid) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (req_valid && req_ready) begin
        pend_addr.push_back(req_addr);
        pend_due.push_back(edge_no + 1 + lat);
        n_fire++;
      end
    end
    @(posedge clk);
    edge_no++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    req_ready      = 1'b1;
    inst_ready     = 1'b1;
    rsp_valid      = 1'b0;
    rsp_data       = '0;
    pend_addr.delete();
    pend_due.delete();
    n_fire = 0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic wait_inst(input int budget, output int w);
    w = 0;
    while (!inst_valid && w < budget) begin
      tick();
      w++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    edge_no  = 0;
    lat      = 1;
    rst      = 1'b0;
    req_ready = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    rsp_valid = 1'b0;
    rsp_data = '0;
    @(negedge clk);
    #1;
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_req_addr", req_addr, 32'd0);

    // Streaming at latency 1 with decode always ready.
    @(negedge clk);
    lat = 1;
    do_reset();
    check("t1_req_valid", {31'd0, req_valid}, 32'd1);
    check("t1_req_addr0", req_addr, 32'h0);
    tick();
    check("t1_req_addr1", req_addr, 32'h4);
    check("t1_no_inst_yet", {31'd0, inst_valid}, 32'd0);
    tick();
    check("t1_valid_a", {31'd0, inst_valid}, 32'd1);
    check("t1_pc_a", inst_pc, 32'h0);
    check("t1_data_a", inst_data, 32'hFFFF_FFFF);
    check("t1_req_addr2", req_addr, 32'h8);
    tick();
    check("t1_pc_b", inst_pc, 32'h4);
    check("t1_data_b", inst_data, 32'hFFFF_FFFB);
    check("t1_req_addr3", req_addr, 32'hC);

    // Decode stalled: credit caps issue at the queue depth.
    lat = 1;
    do_reset();
    inst_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("t2_fires", n_fire, 32'd4);
    check("t2_req_valid_low", {31'd0, req_valid}, 32'd0);
    check("t2_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("t2_req_valid_after_pop", {31'd0, req_valid}, 32'd1);
    check("t2_req_addr_after_pop", req_addr, 32'h10);
    check("t2_head_pc_after_pop", inst_pc, 32'h4);
    for (int i = 0; i < 6; i++) tick();
    check("t2_fires_after_pop", n_fire, 32'd5);
    check("t2_req_valid_low2", {31'd0, req_valid}, 32'd0);

    // Latency 3: redirect with three requests in flight.
    lat = 3;
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("t3_inst_valid_cleared", {31'd0, inst_valid}, 32'd0);
    check("t3_req_addr", req_addr, 32'h100);
    wait_inst(12, waited);
    check("t3_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("t3_wait_cycles", waited, 32'd4);
    check("t3_pc", inst_pc, 32'h100);
    check("t3_data", inst_data, 32'hFFFF_FEFF);
    tick();
    check("t3_pc_next", inst_pc, 32'h104);
    check("t3_data_next", inst_data, 32'hFFFF_FEFB);

    // Redirect coinciding with a fire and a response push, queue non-empty.
    lat = 1;
    do_reset();
    inst_ready = 1'b0;
    tick();
    tick();
    tick();
    check("t4_pre_valid", {31'd0, inst_valid}, 32'd1);
    check("t4_pre_pc", inst_pc, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    check("t4_flushed", {31'd0, inst_valid}, 32'd0);
    check("t4_flushed_pc", inst_pc, 32'h0);
    check("t4_flushed_data", inst_data, 32'h0);
    check("t4_req_addr", req_addr, 32'h200);
    inst_ready = 1'b1;
    wait_inst(12, waited);
    check("t4_wait_cycles", waited, 32'd2);
    check("t4_pc", inst_pc, 32'h200);
    check("t4_data", inst_data, 32'hFFFF_FDFF);

    // PC wrap at the top of the address space.
    lat = 1;
    do_reset();
    req_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("t5_req_addr_top", req_addr, 32'hFFFF_FFFC);
    check("t5_req_valid", {31'd0, req_valid}, 32'd1);
    req_ready = 1'b1;
    tick();
    check("t5_req_addr_wrap", req_addr, 32'h0);
    tick();
    check("t5_pc_top", inst_pc, 32'hFFFF_FFFC);
    check("t5_data_top", inst_data, 32'h0000_0003);
    tick();
    check("t5_pc_wrap", inst_pc, 32'h0);
    check("t5_data_wrap", inst_data, 32'hFFFF_FFFF);

    // Asynchronous reset mid-operation.
    lat = 3;
    do_reset();
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("t6_pre_valid", {31'd0, inst_valid}, 32'd1);
    check("t6_pre_req_valid", {31'd0, req_valid}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("t6_req_valid", {31'd0, req_valid}, 32'd1);
    check("t6_req_addr", req_addr, 32'h0);
    check("t6_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("t6_inst_data", inst_data, 32'h0);
    check("t6_inst_pc", inst_pc, 32'h0);
`ifdef FETCH_STAGE_PERF_EN
    check("t6_perf_fetched", perf_fetched, 32'h0);
    check("t6_perf_stall", perf_stall, 32'h0);
`endif
    pend_addr.delete();
    pend_due.delete();
    rsp_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
